spi_reg_peripheral: RTL and testbench

//  SPI mode-0, write-only register-file target that produces the five 8-bit control registers consumed by
//  pwm_peripheral (output enables, PWM enables, duty cycle). Sits in the TT top level between ui_in[2:0]
//  (SCLK, COPI, nCS) and pwm_peripheral. The SPI pins are asynchronous to clk; all logic runs on clk.

---
 rtl/spi_reg_peripheral.sv | 131 +++++++++++++
 tb/tb_spi_reg_peripheral.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_peripheral.sv
`default_nettype none
// ============================================================================
// Module     : spi_reg_peripheral
// Description: SPI mode-0 write-only target holding five 8-bit control
//              registers for the PWM peripheral; all logic on clk.
// Revision   : 1.0 - initial release
// ============================================================================
module spi_reg_peripheral #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe
);

    localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_SHIFT     = 2'd2;
    localparam logic [1:0] ST_COMMIT    = 2'd3;

    localparam logic [4:0] C_FRAME_BITS = 5'd16;
    localparam logic [4:0] C_CNT_SAT    = 5'd17;
    localparam logic [6:0] C_LAST_REG   = 7'h04;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_copi_sync;
    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic                   r_sclk_d;
    logic                   r_ncs_d;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [15:0] r_shift;

    logic w_sclk_s;
    logic w_copi_s;
    logic w_ncs_s;
    logic w_sclk_rise;
    logic w_ncs_rise;
    logic w_ncs_fall;
    logic [6:0] w_addr;
    logic       w_write_hit;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
    assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_ncs_rise  = w_ncs_s & ~r_ncs_d;
    assign w_ncs_fall  = ~w_ncs_s & r_ncs_d;

    assign w_addr      = r_shift[14:8];
    // Addresses within MAX_ADDR but beyond the last physical register are ignored
    assign w_write_hit = r_shift[15] && (w_addr <= MAX_ADDR) && (w_addr <= C_LAST_REG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_copi_sync <= '0;
            r_ncs_sync  <= '0;
            r_sclk_d    <= 1'b0;
            r_ncs_d     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
            r_sclk_d    <= w_sclk_s;
            r_ncs_d     <= w_ncs_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_WAIT_IDLE;
            r_cnt           <= 5'd0;
            r_shift         <= 16'h0000;
            wr_strobe       <= 1'b0;
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
        end else begin
            wr_strobe <= 1'b0;
            case (r_state)
                // Wait for a quiet bus so a frame already running at reset is dropped whole
                ST_WAIT_IDLE: begin
                    if (w_ncs_s) r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    r_cnt   <= 5'd0;
                    r_shift <= 16'h0000;
                    if (w_ncs_fall) r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // Chip-select release takes priority over a coincident clock edge
                    if (w_ncs_rise) begin
                        r_state <= (r_cnt == C_FRAME_BITS) ? ST_COMMIT : ST_IDLE;
                    end else if (w_sclk_rise) begin
                        r_shift <= {r_shift[14:0], w_copi_s};
                        if (r_cnt != C_CNT_SAT) r_cnt <= r_cnt + 5'd1;
                    end
                end
                ST_COMMIT: begin
                    if (w_write_hit) begin
                        wr_strobe <= 1'b1;
                        case (w_addr)
                            7'h00:   en_reg_out_7_0  <= r_shift[7:0];
                            7'h01:   en_reg_out_15_8 <= r_shift[7:0];
                            7'h02:   en_reg_pwm_7_0  <= r_shift[7:0];
                            7'h03:   en_reg_pwm_15_8 <= r_shift[7:0];
                            default: pwm_duty_cycle  <= r_shift[7:0];
                        endcase
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_WAIT_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_peripheral.sv
`default_nettype none
// ============================================================================
// Module     : tb_spi_reg_peripheral
// Description: Randomised SPI frame bench with a register-file model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_spi_reg_peripheral;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_strobe;

    logic [7:0] exp_regs [0:4];
    logic       exp_strobe;
    logic       chk_en;
    int         n_tests;
    int         n_fail;
    int         strobe_cnt;

    spi_reg_peripheral #(
        .SYNC_STAGES(2),
        .MAX_ADDR   (7'h04)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sclk           (sclk),
        .copi           (copi),
        .ncs            (ncs),
        .en_reg_out_7_0 (en_reg_out_7_0),
        .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0 (en_reg_pwm_7_0),
        .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle (pwm_duty_cycle),
        .wr_strobe      (wr_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, req, $time);
        end
    endtask

    // Continuous check of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("reg0", en_reg_out_7_0, exp_regs[0]);
            cmp("reg1", en_reg_out_15_8, exp_regs[1]);
            cmp("reg2", en_reg_pwm_7_0, exp_regs[2]);
            cmp("reg3", en_reg_pwm_15_8, exp_regs[3]);
            cmp("reg4", pwm_duty_cycle, exp_regs[4]);
            cmp("strobe", {7'd0, wr_strobe}, {7'd0, exp_strobe});
            if (wr_strobe === 1'b1) strobe_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
        exp_strobe = 1'b0;
    endtask

    // Bit i of a frame is w[16-i]; w holds the 16-bit word left-aligned plus one extra bit
    task automatic shift_bits(input logic [16:0] w, input int first, input int last);
        for (int i = first; i < last; i++) begin
            copi = w[16-i];
            tick($urandom_range(4, 6));
            sclk = 1'b1;
            tick($urandom_range(4, 6));
            sclk = 1'b0;
        end
    endtask

    // Raise ncs and apply the frame's architectural effect at the commit edge
    task automatic end_frame(input logic [15:0] word, input int nb, input bit valid);
        tick($urandom_range(2, 4));
        ncs = 1'b1;
        repeat (4) @(posedge clk);
        if (valid && nb == 16 && word[15] && word[14:8] <= 7'h04) begin
            exp_regs[int'(word[14:8])] = word[7:0];
            exp_strobe = 1'b1;
        end
        @(posedge clk);
        exp_strobe = 1'b0;
        tick(3);
    endtask

    task automatic frame(input logic [15:0] word, input int nb);
        ncs = 1'b0;
        tick($urandom_range(2, 4));
        shift_bits({word, 1'b0}, 0, nb);
        end_frame(word, nb, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_model();
        tick(2);
        rst_n = 1'b1;
        tick(5);
    endtask

    int s0;
    int nb;
    logic [15:0] word;

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        strobe_cnt = 0;
        chk_en     = 1'b0;
        rst_n      = 1'b0;
        sclk       = 1'b0;
        copi       = 1'b0;
        ncs        = 1'b1;
        clear_model();
        tick(1);
        chk_en = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(5);
        cmp("reset_reg0", en_reg_out_7_0, 8'h00);
        cmp("reset_duty", pwm_duty_cycle, 8'h00);

        // T1
        frame(16'h80F0, 16);
        cmp("t1_reg0", en_reg_out_7_0, 8'hF0);
        cmp("t1_strobes", 8'(strobe_cnt), 8'd1);

        // T2
        s0 = strobe_cnt;
        frame(16'h8480, 16);
        frame(16'h83AA, 16);
        cmp("t2_duty", pwm_duty_cycle, 8'h80);
        cmp("t2_pwm_hi", en_reg_pwm_15_8, 8'hAA);
        cmp("t2_strobes", 8'(strobe_cnt - s0), 8'd2);

        // T3
        s0 = strobe_cnt;
        frame(16'h8555, 16);
        frame(16'h0077, 16);
        cmp("t3_reg0", en_reg_out_7_0, 8'hF0);
        cmp("t3_strobes", 8'(strobe_cnt - s0), 8'd0);

        // T4
        s0 = strobe_cnt;
        frame(16'h813C, 15);
        frame(16'h813C, 17);
        cmp("t4_reg1", en_reg_out_15_8, 8'h00);
        cmp("t4_strobes", 8'(strobe_cnt - s0), 8'd0);

        // T5: reset mid-frame, frame tail must be ignored
        ncs = 1'b0;
        tick(3);
        shift_bits({16'h8211, 1'b0}, 0, 9);
        rst_n = 1'b0;
        clear_model();
        tick(2);
        rst_n = 1'b1;
        tick(2);
        shift_bits({16'h8211, 1'b0}, 9, 16);
        end_frame(16'h8211, 16, 1'b0);
        cmp("t5_reg2_dropped", en_reg_pwm_7_0, 8'h00);
        frame(16'h8222, 16);
        cmp("t5_reg2", en_reg_pwm_7_0, 8'h22);

        // T6
        for (int a = 0; a < 5; a++) frame({1'b1, 7'(a), 8'hFF}, 16);
        s0 = strobe_cnt;
        shift_bits({16'h80AB, 1'b1}, 0, 17);
        tick(6);
        cmp("t6_reg3", en_reg_pwm_15_8, 8'hFF);
        cmp("t6_strobes", 8'(strobe_cnt - s0), 8'd0);
        do_reset();
        cmp("t6_reg0_rst", en_reg_out_7_0, 8'h00);
        cmp("t6_duty_rst", pwm_duty_cycle, 8'h00);

        // Random frames
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 7))
                0:       nb = 15;
                1:       nb = 17;
                default: nb = 16;
            endcase
            word = 16'($urandom);
            if ($urandom_range(0, 3) != 0) word[14:8] = 7'($urandom_range(0, 5));
            frame(word, nb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
